// File: rtl/ysyx_24110015_decode_queue_pkg.sv
// ysyx_24110015_decode_queue_pkg: shared RV opcodes, itype bit indices and system-instruction encodings
package ysyx_24110015_decode_queue_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_R32    = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam int IT_R = 0;
    localparam int IT_I = 1;
    localparam int IT_S = 2;
    localparam int IT_B = 3;
    localparam int IT_U = 4;
    localparam int IT_J = 5;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_ECALL  = 32'h00000073;
endpackage

// File: rtl/ysyx_24110015_decode_queue_if.sv
// ysyx_24110015_decode_queue_if: enqueue/dequeue handshake and decoded head fields
interface ysyx_24110015_decode_queue_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
    logic flush;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [XLEN-1:0] in_pc, out_pc, imm;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic [4:0] rs1, rs2, rd;
    logic [5:0] itype;
    logic ebreak, ecall, illegal;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input in_ready, out_valid, out_pc, imm, opcode, func7, func3, rs1, rs2, rd, itype, ebreak, ecall, illegal, count
    );
    modport slave (
        input flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, imm, opcode, func7, func3, rs1, rs2, rd, itype, ebreak, ecall, illegal, count
    );
endinterface

// File: rtl/ysyx_24110015_inst_dec.sv
// ysyx_24110015_inst_dec: combinational RV instruction decode into fields, immediate, one-hot type and flags
module ysyx_24110015_inst_dec
    import ysyx_24110015_decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      itype,
    output logic            ebreak,
    output logic            ecall,
    output logic            illegal
);
    logic std;
    logic signed [31:0] imm32;
    assign std    = inst[1:0] == 2'b11;
    assign opcode = inst[6:0];
    assign func3  = inst[14:12];
    assign func7  = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];
    always_comb begin
        itype = '0;
        itype[IT_R] = std && (opcode == OP_R || (XLEN == 64 && opcode == OP_R32));
        itype[IT_I] = std && (opcode == OP_LOAD || opcode == OP_JALR || opcode == OP_IMM || opcode == OP_FENCE ||
                              opcode == OP_SYSTEM || (XLEN == 64 && opcode == OP_IMM32));
        itype[IT_S] = std && opcode == OP_STORE;
        itype[IT_B] = std && opcode == OP_BRANCH;
        itype[IT_U] = std && (opcode == OP_LUI || opcode == OP_AUIPC);
        itype[IT_J] = std && opcode == OP_JAL;
    end
    // build as signed 32 bits so the width cast sign-extends for XLEN=64 (including U-type)
    assign imm32 = itype[IT_I] ? {{20{inst[31]}}, inst[31:20]} :
                   itype[IT_S] ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                   itype[IT_B] ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                   itype[IT_U] ? {inst[31:12], 12'b0} :
                   itype[IT_J] ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : '0;
    assign imm     = XLEN'(imm32);
    assign illegal = ~|itype;
    assign ebreak  = inst == INST_EBREAK;
    assign ecall   = inst == INST_ECALL;
endmodule

// File: rtl/ysyx_24110015_decode_queue.sv
// ysyx_24110015_decode_queue: circular instruction queue presenting the decoded head entry
module ysyx_24110015_decode_queue
    import ysyx_24110015_decode_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    ysyx_24110015_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [CW-1:0]   cnt;
    logic            push, pop, dec_illegal;
    logic [31:0]     head_inst;
    assign bus.in_ready  = cnt != CW'(DEPTH);
    assign bus.out_valid = cnt != '0;
    assign bus.count     = cnt;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (bus.flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= push ? wp + 1'b1 : wp;
            rp  <= pop ? rp + 1'b1 : rp;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            inst_mem[wp] <= bus.in_inst;
            pc_mem[wp]   <= bus.in_pc;
        end
    end
    // an all-zero word decodes to zero fields/imm/itype, so only the illegal flag needs gating
    assign head_inst   = bus.out_valid ? inst_mem[rp] : 32'h0;
    assign bus.out_pc  = bus.out_valid ? pc_mem[rp] : '0;
    assign bus.illegal = bus.out_valid && dec_illegal;
    ysyx_24110015_inst_dec #(.XLEN(XLEN)) u_dec (
        .inst    (head_inst),
        .opcode  (bus.opcode),
        .func3   (bus.func3),
        .func7   (bus.func7),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .rd      (bus.rd),
        .imm     (bus.imm),
        .itype   (bus.itype),
        .ebreak  (bus.ebreak),
        .ecall   (bus.ecall),
        .illegal (dec_illegal)
    );
endmodule

// File: tb/tb_ysyx_24110015_decode_queue.sv
// tb_ysyx_24110015_decode_queue: vector table plus scoreboard checking of the decode queue
module tb_ysyx_24110015_decode_queue;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [5:0]  itype;
        logic [63:0] imm;
        logic        ebreak;
        logic        ecall;
        logic        illegal;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    ysyx_24110015_decode_queue_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();
    ysyx_24110015_decode_queue_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();
    ysyx_24110015_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) u32 (.clk(clk), .rst(rst), .bus(b32));
    ysyx_24110015_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) u64 (.clk(clk), .rst(rst), .bus(b64));
    vec_t tv [12];
    vec_t x64 [4];
    vec_t sb [$];
    vec_t cur;
    vec_t idle;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input logic vld, input logic ordy, input logic fl);
        cur = v;
        b32.in_valid = vld;
        b32.in_inst = v.inst;
        b32.in_pc = v.pc[31:0];
        b32.out_ready = ordy;
        b32.flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 10 && sb.size() != 0; k++) step(idle, 1'b0, 1'b1, 1'b0);
        chk(name, 64'(b32.count), 64'd0);
    endtask

    // scoreboard: compare head against model, then commit the handshake the model predicts
    always @(negedge clk) begin
        vec_t e;
        bit full;
        if (!rst) sb.delete();
        chk("count", 64'(b32.count), 64'(sb.size()));
        chk("in_ready", 64'(b32.in_ready), 64'(sb.size() != DEPTH));
        chk("out_valid", 64'(b32.out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            e = sb[0];
            chk("out_pc", 64'(b32.out_pc), {32'h0, e.pc[31:0]});
            chk("opcode", 64'(b32.opcode), 64'(e.inst[6:0]));
            chk("rd", 64'(b32.rd), 64'(e.inst[11:7]));
            chk("rs1_rs2", 64'({b32.rs1, b32.rs2}), 64'({e.inst[19:15], e.inst[24:20]}));
            chk("func3_func7", 64'({b32.func3, b32.func7}), 64'({e.inst[14:12], e.inst[31:25]}));
            chk("itype", 64'(b32.itype), 64'(e.itype));
            chk("imm", 64'(b32.imm), {32'h0, e.imm[31:0]});
            chk("flags", 64'({b32.ebreak, b32.ecall, b32.illegal}), 64'({e.ebreak, e.ecall, e.illegal}));
        end else begin
            chk("idle_fields", 64'({b32.itype, b32.ebreak, b32.ecall, b32.illegal, b32.opcode, b32.rd,
                                    b32.rs1, b32.rs2, b32.func3, b32.func7}), 64'd0);
            chk("idle_imm_pc", {b32.imm, b32.out_pc}, 64'd0);
        end
        if (rst) begin
            if (b32.flush) sb.delete();
            else begin
                full = sb.size() == DEPTH;
                if (b32.out_ready && sb.size() != 0) void'(sb.pop_front());
                if (b32.in_valid && !full) sb.push_back(cur);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{32'h00100073, 64'h0, 6'b000010, 64'd1, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{32'h00000073, 64'h0, 6'b000010, 64'd0, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{32'h002081B3, 64'h0, 6'b000001, 64'd0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{32'hFFF00093, 64'h0, 6'b000010, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{32'hFE20AC23, 64'h0, 6'b000100, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{32'h00208463, 64'h0, 6'b001000, 64'd8, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{32'hFE000FE3, 64'h0, 6'b001000, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{32'h12345097, 64'h0, 6'b010000, 64'h12345000, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{32'h800002B7, 64'h0, 6'b010000, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{32'h0000007F, 64'h0, 6'b000000, 64'd0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{32'h00000001, 64'h0, 6'b000000, 64'd0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{32'hFFDFF0EF, 64'h0, 6'b100000, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) tv[i].pc = 64'h80000000 + 64'(4 * i);
        x64[0] = '{32'h800002B7, 64'h8000000000001000, 6'b010000, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0};
        x64[1] = '{32'hFFDFF0EF, 64'h8000000000001004, 6'b100000, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b0};
        x64[2] = '{32'h0000003B, 64'h8000000000001008, 6'b000001, 64'd0, 1'b0, 1'b0, 1'b0};
        x64[3] = '{32'h0000001B, 64'h800000000000100C, 6'b000010, 64'd0, 1'b0, 1'b0, 1'b0};
        idle = '{32'h0, 64'h0, 6'b0, 64'h0, 1'b0, 1'b0, 1'b0};
        cur = idle;
        b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1'b0; b32.flush = 1'b0;
        b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1'b0; b64.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // table: push each vector, then pop it one cycle later
        for (int i = 0; i < 12; i++) begin
            step(tv[i], 1'b1, 1'b0, 1'b0);
            step(idle, 1'b0, 1'b1, 1'b0);
        end
        // fill to DEPTH, refused fifth push, refused push even with simultaneous pop
        for (int i = 0; i < DEPTH; i++) step(tv[i], 1'b1, 1'b0, 1'b0);
        chk("full_in_ready", 64'(b32.in_ready), 64'd0);
        step(tv[4], 1'b1, 1'b0, 1'b0);
        step(tv[4], 1'b1, 1'b0, 1'b0);
        step(tv[5], 1'b1, 1'b1, 1'b0);
        chk("full_push_pop_count", 64'(b32.count), 64'd3);
        drain("drain_full");
        // steady push+pop at count 2, wrapping the pointers twice
        step(tv[6], 1'b1, 1'b0, 1'b0);
        step(tv[7], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(tv[(i + 8) % 12], 1'b1, 1'b1, 1'b0);
        chk("steady_count", 64'(b32.count), 64'd2);
        drain("drain_steady");
        // flush with a concurrent push drops everything
        for (int i = 0; i < 3; i++) step(tv[i + 2], 1'b1, 1'b0, 1'b0);
        step(tv[0], 1'b1, 1'b1, 1'b1);
        chk("flush_count", 64'(b32.count), 64'd0);
        chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
        step(idle, 1'b0, 1'b0, 1'b0);
        step(tv[8], 1'b1, 1'b0, 1'b0);
        drain("drain_after_flush");
        // XLEN=64 instance: sign-extended U/J immediates and RV64-only opcodes
        for (int i = 0; i < 4; i++) begin
            b64.in_valid = 1'b1; b64.in_inst = x64[i].inst; b64.in_pc = x64[i].pc;
            @(posedge clk);
            #1;
        end
        b64.in_valid = 1'b0;
        chk("x64_count", 64'(b64.count), 64'd4);
        chk("x64_lui_rd", 64'(b64.rd), 64'd5);
        for (int i = 0; i < 4; i++) begin
            chk("x64_pc", b64.out_pc, x64[i].pc);
            chk("x64_itype", 64'(b64.itype), 64'(x64[i].itype));
            chk("x64_imm", b64.imm, x64[i].imm);
            chk("x64_illegal", 64'(b64.illegal), 64'd0);
            b64.out_ready = 1'b1;
            @(posedge clk);
            #1;
            b64.out_ready = 1'b0;
        end
        chk("x64_empty", 64'(b64.count), 64'd0);
        // illegal words queue normally; asynchronous reset drops entries mid-cycle
        step(tv[9], 1'b1, 1'b0, 1'b0);
        step(tv[10], 1'b1, 1'b0, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);
        step(tv[0], 1'b1, 1'b0, 1'b0);
        step(tv[1], 1'b1, 1'b0, 1'b0);
        b32.in_valid = 1'b0;
        chk("pre_reset_count", 64'(b32.count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(b32.count), 64'd0);
        chk("async_rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("async_rst_illegal", 64'(b32.illegal), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(tv[3], 1'b1, 1'b0, 1'b0);
        step(idle, 1'b0, 1'b1, 1'b0);
        step(idle, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
